adc_serial_tx: RTL and testbench
================================

Name: adc_serial_tx

Overview:
- Transmitter side of the per-channel ADC serial link: serializes CHAN parallel 12-bit samples into per-channel serial bitstreams with a bit clock and a frame marker.
- Used as an on-board/bench ADC emulator driving the digitizer's adcdata_p / adc_clk / adc_frame inputs. This lets the digitizer capture and readout chain run without the physical ADC.
- Sends bursts of a programmable number of words. Each word comes from a selectable pattern source (ramp, fixed, channel ID, external).

Parameters:
- CHAN, 8, number of serial channels.
- ADC_WIDTH, 12, bits per sample word; fixed at 12 (frame timing below assumes it).
- CNT_WIDTH, 12, width of burst length counter.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a burst when idle, ignored otherwise.
- stop  in  1  level/pulse; requests end of burst after the current word.
- how_many  in  CNT_WIDTH  words per burst, sampled on start.
- pattern_sel  in  2  0=ramp, 1=fixed, 2=channel ID, 3=external; sampled on start.
- fixed_word  in  ADC_WIDTH  value for pattern 1, sampled at each word load.
- ext_sample  in  CHAN*ADC_WIDTH  external words, channel i at [(i+1)*12-1 -: 12].
- ext_ack  out  1  one-cycle pulse when ext_sample is consumed (pattern 3 only).
- adc_data_p  out  CHAN  serial data, MSB first.
- adc_clk  out  1  bit clock, CLK/2.
- adc_frame  out  1  word frame marker.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse at burst end.
- word_cnt  out  CNT_WIDTH  words completed in the current or last burst.

Behaviour:
- Reset (RST_n low, async): state IDLE. Outputs adc_data_p=0, adc_clk=0, adc_frame=0, busy=0, done=0, ext_ack=0, word_cnt=0. Internal ramp_base=0. Reset mid-burst aborts immediately with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on start when how_many != 0:
  - Latch how_many and pattern_sel, clear word_cnt, load word 0.
  - busy=1 from the next cycle.
- IDLE -> DONE on start when how_many == 0: no bits sent.
- Word timing:
  - Each bit lasts 2 CLK cycles: phase 0 then phase 1, so one word is 24 cycles.
  - adc_data_p[i] = word_i[b], held across both phases; b runs 11 down to 0.
  - adc_clk = 0 in phase 0 and 1 in phase 1. The receiver samples on the adc_clk rising edge, mid-bit.
  - adc_frame = 1 while b in 11..6, 0 for b in 5..0.
  - First bit (b=11, phase 0) appears on outputs in the cycle after start is sampled.
- Word end (b=0, phase 1): word_cnt increments.
  - If word_cnt+1 == how_many, or stop has been seen since the last load: -> DONE.
  - Otherwise load the next word and continue at b=11 with no idle cycle.
- stop sampled in IDLE or DONE has no effect.
- DONE (1 cycle): done=1, busy=0, data/clk/frame=0 -> IDLE. A start in DONE is ignored.
- Pattern sources (word_i at load):
  - Ramp: (ramp_base + i) mod 4096. ramp_base increments by 1 per word and persists across bursts; cleared only by reset.
  - Fixed: fixed_word on all channels.
  - Channel ID: {i[3:0], i[3:0], i[3:0]}.
  - External: ext_sample slice i. ext_ack pulses in the cycle the word is loaded.
- Outputs are registered: no combinational path from inputs to outputs.

Test Plan:
- Ramp, how_many=3, fresh reset → ch0 words 0,1,2; ch2 words 2,3,4. busy high exactly 72 cycles, done pulse in the following cycle, word_cnt=3.
- Fixed 0xA53, how_many=1 → every channel shifts 1010_0101_0011 MSB first. adc_frame high for the first 12 cycles and low for the next 12; adc_clk toggles every cycle, starting low.
- Channel ID, CHAN=8 → channel 5 word 0x555, channel 7 word 0x777. A second back-to-back ramp burst continues from the previous ramp_base.
- how_many=0 start → no adc_clk toggles, busy stays 0, done pulses 1 cycle after start.
- how_many=10, stop pulsed during bit 4 of word 2 → word 2 completes, done follows, word_cnt=3, adc_frame/adc_data_p back to 0.
- External pattern, RST_n asserted mid-word → all outputs 0 immediately with no done pulse. After release, start sends ext_sample with one ext_ack per word.

Source files
------------

// File: rtl/adc_serial_tx.sv
// adc_serial_tx: ADC emulator transmitter. Serializes CHAN 12-bit pattern
// words MSB first, two CLK cycles per bit, with a CLK/2 bit clock and a
// frame marker high for the first six bits of each word.

// Per-channel word register, pattern mux and serial data flop.
module adc_serial_tx_lane #(
    parameter int LANE      = 0,
    parameter int ADC_WIDTH = 12
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic                 clear,
    input  logic [3:0]           nxt_bit,
    input  logic [1:0]           pat_sel,
    input  logic [ADC_WIDTH-1:0] ramp_base,
    input  logic [ADC_WIDTH-1:0] fixed_word,
    input  logic [ADC_WIDTH-1:0] ext_word,
    output logic                 data
);
    localparam logic [3:0] ID = 4'(LANE);

    logic [ADC_WIDTH-1:0] word_q, word_d;

    // select the word this lane would load right now
    always_comb begin
        word_d = '0;
        case (pat_sel)
            2'd0: word_d = ramp_base + ADC_WIDTH'(LANE);
            2'd1: word_d = fixed_word;
            2'd2: word_d = {ID, ID, ID};
            default: word_d = ext_word;
        endcase
    end

    // hold the word and present one bit; the MSB goes out with the load itself
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            word_q <= '0;
            data   <= 1'b0;
        end else if (load) begin
            word_q <= word_d;
            data   <= word_d[ADC_WIDTH-1];
        end else if (advance) begin
            data <= word_q[nxt_bit];
        end else if (clear) begin
            data <= 1'b0;
        end
    end
endmodule

module adc_serial_tx #(
    parameter int CHAN      = 8,
    parameter int ADC_WIDTH = 12,
    parameter int CNT_WIDTH = 12
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic [CNT_WIDTH-1:0]      how_many,
    input  logic [1:0]                pattern_sel,
    input  logic [ADC_WIDTH-1:0]      fixed_word,
    input  logic [CHAN*ADC_WIDTH-1:0] ext_sample,
    output logic                      ext_ack,
    output logic [CHAN-1:0]           adc_data_p,
    output logic                      adc_clk,
    output logic                      adc_frame,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_WIDTH-1:0]      word_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] len_q;
    logic [1:0]           pat_q;
    logic [3:0]           bit_q;
    logic                 phase_q;
    logic                 stop_seen;
    logic [ADC_WIDTH-1:0] ramp_base;

    logic       start_go, word_end, last_word, load, advance, clear;
    logic [1:0] pat_now;
    logic [3:0] nxt_bit;

    // a stop arriving in the last cycle of a word still ends the burst there
    assign start_go  = (state == S_IDLE) && start && (how_many != '0);
    assign word_end  = (state == S_SHIFT) && phase_q && (bit_q == 4'd0);
    assign last_word = (word_cnt + CNT_WIDTH'(1) == len_q) || stop_seen || stop;
    assign load      = start_go || (word_end && !last_word);
    assign clear     = word_end && last_word;
    assign advance   = (state == S_SHIFT) && phase_q && (bit_q != 4'd0);
    assign pat_now   = start_go ? pattern_sel : pat_q;
    assign nxt_bit   = bit_q - 4'd1;

    for (genvar g = 0; g < CHAN; g++) begin : g_lane
        adc_serial_tx_lane #(.LANE(g), .ADC_WIDTH(ADC_WIDTH)) u_lane (
            .CLK        (CLK),
            .RST_n      (RST_n),
            .load       (load),
            .advance    (advance),
            .clear      (clear),
            .nxt_bit    (nxt_bit),
            .pat_sel    (pat_now),
            .ramp_base  (ramp_base),
            .fixed_word (fixed_word),
            .ext_word   (ext_sample[g*ADC_WIDTH +: ADC_WIDTH]),
            .data       (adc_data_p[g])
        );
    end

    // burst sequencer: bit/phase counters, framing outputs and word accounting
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= S_IDLE;
            len_q     <= '0;
            pat_q     <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            stop_seen <= 1'b0;
            ramp_base <= '0;
            ext_ack   <= 1'b0;
            adc_clk   <= 1'b0;
            adc_frame <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            word_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            ext_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        word_cnt  <= '0;
                        len_q     <= how_many;
                        pat_q     <= pattern_sel;
                        stop_seen <= 1'b0;
                        if (start_go) begin
                            state     <= S_SHIFT;
                            busy      <= 1'b1;
                            bit_q     <= 4'd11;
                            phase_q   <= 1'b0;
                            adc_clk   <= 1'b0;
                            adc_frame <= 1'b1;
                            ext_ack   <= (pattern_sel == 2'd3);
                            if (pattern_sel == 2'd0) ramp_base <= ramp_base + 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (stop) stop_seen <= 1'b1;
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        adc_clk <= 1'b1;
                    end else if (advance) begin
                        bit_q     <= nxt_bit;
                        phase_q   <= 1'b0;
                        adc_clk   <= 1'b0;
                        adc_frame <= (nxt_bit >= 4'd6);
                    end else begin
                        word_cnt <= word_cnt + CNT_WIDTH'(1);
                        adc_clk  <= 1'b0;
                        phase_q  <= 1'b0;
                        if (last_word) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            adc_frame <= 1'b0;
                        end else begin
                            bit_q     <= 4'd11;
                            adc_frame <= 1'b1;
                            stop_seen <= 1'b0;
                            ext_ack   <= (pat_q == 2'd3);
                            if (pat_q == 2'd0) ramp_base <= ramp_base + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_serial_tx.sv
// Bench for adc_serial_tx: every burst is predicted from a word-list model
// (per-channel words, then 12 bits x 2 phases per word) and compared cycle
// by cycle on the falling edge.
module tb_adc_serial_tx;
    localparam int CHAN = 8;
    localparam int W    = 12;
    localparam int CW   = 12;

    logic            CLK = 1'b0;
    logic            RST_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [CW-1:0]   how_many = '0;
    logic [1:0]      pattern_sel = '0;
    logic [W-1:0]    fixed_word = '0;
    logic [CHAN*W-1:0] ext_sample = '0;
    logic            ext_ack, adc_clk, adc_frame, busy, done;
    logic [CHAN-1:0] adc_data_p;
    logic [CW-1:0]   word_cnt;

    adc_serial_tx #(.CHAN(CHAN), .ADC_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .stop(stop),
        .how_many(how_many), .pattern_sel(pattern_sel), .fixed_word(fixed_word),
        .ext_sample(ext_sample), .ext_ack(ext_ack), .adc_data_p(adc_data_p),
        .adc_clk(adc_clk), .adc_frame(adc_frame), .busy(busy), .done(done),
        .word_cnt(word_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int mdl_ramp = 0;
    logic [W-1:0] cur_words [CHAN];

    function automatic logic [31:0] obs();
        return {7'd0, busy, done, ext_ack, adc_clk, adc_frame, word_cnt, adc_data_p};
    endfunction

    function automatic logic [31:0] expv(logic bsy, logic dn, logic ack, logic ck,
                                         logic fr, logic [CW-1:0] wc, logic [CHAN-1:0] d);
        return {7'd0, bsy, dn, ack, ck, fr, wc, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (busy,done,ack,clk,frame,cnt,data)", tag, got, exp);
        end
    endtask

    // new random inputs for the next load, and the words the model expects
    task automatic set_words(input int pat);
        fixed_word = W'($urandom);
        for (int i = 0; i < CHAN; i++) ext_sample[i*W +: W] = W'($urandom);
        for (int i = 0; i < CHAN; i++) begin
            logic [3:0] id;
            id = 4'(i);
            case (pat)
                0: cur_words[i] = W'((mdl_ramp + i) % 4096);
                1: cur_words[i] = fixed_word;
                2: cur_words[i] = {id, id, id};
                default: cur_words[i] = ext_sample[i*W +: W];
            endcase
        end
        if (pat == 0) mdl_ramp = (mdl_ramp + 1) % 4096;
    endtask

    task automatic run_burst(input int hm, input int pat, input int stop_w, input bit poke);
        int nw;
        logic [CHAN-1:0] d;
        nw = (stop_w >= 0 && stop_w + 1 < hm) ? stop_w + 1 : hm;
        @(negedge CLK);
        how_many = CW'(hm); pattern_sel = 2'(pat); start = 1'b1;
        if (hm > 0) set_words(pat);
        @(negedge CLK);
        start = 1'b0;
        how_many = CW'($urandom); pattern_sel = 2'($urandom);
        for (int w = 0; w < nw; w++)
            for (int b = W - 1; b >= 0; b--)
                for (int ph = 0; ph < 2; ph++) begin
                    for (int i = 0; i < CHAN; i++) d[i] = cur_words[i][b];
                    chk("bit", obs(), expv(1'b1, 1'b0, (pat == 3 && b == 11 && ph == 0),
                                           ph[0], (b >= 6), CW'(w), d));
                    stop  = (w == stop_w && b == 4 && ph == 0);
                    start = (poke && w == 0 && b == 9);
                    if (b == 0 && ph == 1 && w + 1 < nw) set_words(pat);
                    @(negedge CLK);
                end
        stop = 1'b0; start = 1'b0;
        chk("done", obs(), expv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CW'(nw), '0));
        start = 1'b1; stop = 1'b1; how_many = CW'(5);
        @(negedge CLK);
        start = 1'b0; stop = 1'b0;
        chk("idle", obs(), expv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(nw), '0));
        @(negedge CLK);
        chk("idle2", obs(), expv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(nw), '0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset", obs(), '0);
        RST_n = 1'b1;
        @(negedge CLK);
        chk("post_reset", obs(), '0);

        run_burst(3, 0, -1, 1'b0);          // ramp from zero
        run_burst(1, 1, -1, 1'b0);          // fixed word
        run_burst(2, 2, -1, 1'b1);          // channel ID, stray start mid-burst
        run_burst(2, 0, -1, 1'b0);          // ramp continues
        run_burst(0, 0, -1, 1'b0);          // empty burst
        run_burst(10, 1, 2, 1'b0);          // stop during word 2

        @(negedge CLK); stop = 1'b1;        // stop while idle is ignored
        @(negedge CLK); stop = 1'b0;
        run_burst(2, 3, -1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            int hm, pat, sw;
            hm  = $urandom_range(0, 4);
            pat = $urandom_range(0, 3);
            sw  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            run_burst(hm, pat, sw, 1'($urandom));
        end

        // asynchronous abort in the middle of an external-pattern word
        @(negedge CLK);
        how_many = CW'(4); pattern_sel = 2'd3; start = 1'b1;
        set_words(3);
        @(negedge CLK); start = 1'b0;
        repeat (30) @(negedge CLK);
        RST_n = 1'b0;
        #1 chk("rst_abort", obs(), '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("rst_hold", obs(), '0);
        end
        RST_n = 1'b1;
        mdl_ramp = 0;
        @(negedge CLK);
        chk("rst_release", obs(), '0);
        run_burst(2, 3, -1, 1'b0);
        run_burst(2, 0, -1, 1'b0);          // ramp restarts at zero after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
